// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states,
// and small opcode classification helpers.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } alu_state_e;

    // Ops that use the restoring divider.
    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Ops that take one iteration per operand bit.
    function automatic logic is_iter_op(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || is_div_op(op);
    endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring divider, one quotient bit per step. i_start loads the operands,
// each i_step retires one bit. o_quot/o_rem show the values *after* the
// current step so the owner can capture the final answer on the last step,
// flagged by o_done. Divide-by-zero is resolved by the owner.
module alu_seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    // Partial remainder shifted left with the next dividend bit; the true
    // difference is always below the divisor, so WIDTH bits hold it.
    assign w_shift  = {r_rem, r_q[WIDTH-1]};
    assign w_borrow = (w_shift < {1'b0, r_div});
    assign w_diff   = w_shift[WIDTH-1:0] - r_div;
    assign o_quot   = {r_q[WIDTH-2:0], ~w_borrow};
    assign o_rem    = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
    assign o_done   = r_busy && (r_cnt == '0);

    // Load on start, then retire one quotient bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_q    <= i_a;
            r_rem  <= '0;
            r_div  <= i_b;
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_busy <= 1'b1;
        end else if (i_step && r_busy) begin
            r_q   <= o_quot;
            r_rem <= o_rem;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU. One request in (valid/ready), one response out
// (valid/ready). Single-cycle ops answer 2 cycles after accept, MUL/DIV/MOD
// after WIDTH+1. Define ALU_SEQ_DBZ_ERR_EN to add rsp_err (divide by zero or
// unsupported opcode).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [OP_W-1:0]    req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_n,
    output logic               rsp_z,
    output logic               rsp_c,
    output logic               rsp_v,
`ifdef ALU_SEQ_DBZ_ERR_EN
    output logic               rsp_err,
`endif
    output alu_state_e         dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    alu_state_e         r_state;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [2*WIDTH-1:0] r_result;
    logic               r_n, r_z, r_c, r_v;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [OP_W-1:0]    r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    logic               w_accept;
    logic               w_div_done;
    logic               w_iter_last;
    logic [WIDTH-1:0]   w_quot, w_rem;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_shift_big;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_result;
    logic               w_n, w_z, w_c, w_v;

    assign w_accept    = req_valid && r_req_ready;
    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff      = r_a - r_b;
    assign w_shift_big = (32'(r_b) >= 32'(WIDTH));
    assign w_mul_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_iter_last = is_div_op(r_op) ? w_div_done : (r_cnt == '0);

    alu_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept && is_div_op(req_op)),
        .i_step  ((r_state == ITER) && is_div_op(r_op)),
        .i_a     (req_a),
        .i_b     (req_b),
        .o_quot  (w_quot),
        .o_rem   (w_rem),
        .o_done  (w_div_done)
    );

    // Response value for the registered operands; captured by EXEC or the
    // last ITER cycle.
    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_result[WIDTH-1:0] = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result[WIDTH-1:0] = w_diff;
                w_c = (r_a < r_b);
                w_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_MUL: w_result = w_mul_next;
            OP_DIV: w_result[WIDTH-1:0] = (r_b == '0) ? '1 : w_quot;
            OP_MOD: w_result[WIDTH-1:0] = (r_b == '0) ? r_a : w_rem;
            OP_AND: w_result[WIDTH-1:0] = r_a & r_b;
            OP_OR:  w_result[WIDTH-1:0] = r_a | r_b;
            OP_XOR: w_result[WIDTH-1:0] = r_a ^ r_b;
            OP_SHL: w_result[WIDTH-1:0] = w_shift_big ? '0 : (r_a << r_b);
            OP_SHR: w_result[WIDTH-1:0] = w_shift_big ? '0 : (r_a >> r_b);
            default: ;
        endcase
    end

    assign w_z = (w_result == '0);
    assign w_n = (r_op == OP_MUL) ? w_result[2*WIDTH-1] : w_result[WIDTH-1];

`ifdef ALU_SEQ_DBZ_ERR_EN
    logic r_err;
    logic w_err;
    assign w_err   = (is_div_op(r_op) && (r_b == '0)) || (r_op > OP_SHR);
    assign rsp_err = r_err;

    // Error flag captured alongside the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (((r_state == EXEC) || ((r_state == ITER) && w_iter_last))) begin
            r_err <= w_err;
        end
    end
`endif

    // Control FSM with registered handshake outputs and iterative multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            {r_n, r_z, r_c, r_v} <= 4'b0000;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_op        <= req_op;
                        r_req_ready <= 1'b0;
                        if (is_iter_op(req_op)) begin
                            r_state  <= ITER;
                            r_cnt    <= CNT_W'(WIDTH - 1);
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, req_a};
                            r_mplier <= req_b;
                        end else begin
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_result    <= w_result;
                    {r_n, r_z, r_c, r_v} <= {w_n, w_z, w_c, w_v};
                    r_rsp_valid <= 1'b1;
                    r_state     <= DONE;
                end
                ITER: begin
                    r_acc    <= w_mul_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_iter_last) begin
                        r_result    <= w_result;
                        {r_n, r_z, r_c, r_v} <= {w_n, w_z, w_c, w_v};
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_n      = r_n;
    assign rsp_z      = r_z;
    assign rsp_c      = r_c;
    assign rsp_v      = r_v;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=4). Expected responses come from an arithmetic
// model of the opcode rules and are queued at request time.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a, req_b, req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_n, rsp_z, rsp_c, rsp_v;
    alu_state_e dbg_state;
    logic       rsp_err;

`ifdef ALU_SEQ_DBZ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
    assign rsp_err = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];

    alu_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .rsp_c      (rsp_c),
        .rsp_v      (rsp_v),
`ifdef ALU_SEQ_DBZ_ERR_EN
        .rsp_err    (rsp_err),
`endif
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference: {err, n, z, c, v, result[7:0]} from plain arithmetic.
    function automatic logic [12:0] model(input int a, input int b, input int op);
        int res, n, z, c, v, e, sa, sb, s;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        res = 0; c = 0; v = 0; e = 0;
        case (op)
            0: begin s = a + b; res = s % 16; c = (s > 15); v = ((sa + sb) > 7) || ((sa + sb) < -8); end
            1: begin res = (a - b + 16) % 16; c = (a < b); v = ((sa - sb) > 7) || ((sa - sb) < -8); end
            2: res = a * b;
            3: begin if (b == 0) begin res = 15; e = 1; end else res = a / b; end
            4: begin if (b == 0) begin res = a; e = 1; end else res = a % b; end
            5: res = a & b;
            6: res = a | b;
            7: res = a ^ b;
            8: res = (b >= 4) ? 0 : (a * (2 ** b)) % 16;
            9: res = (b >= 4) ? 0 : a / (2 ** b);
            default: e = 1;
        endcase
        n = (op == 2) ? (res / 128) % 2 : (res / 8) % 2;
        z = (res == 0);
        if (!ERR_EN) e = 0;
        return {e[0], n[0], z[0], c[0], v[0], res[7:0]};
    endfunction

    function automatic logic [12:0] observed();
        return {rsp_err, rsp_n, rsp_z, rsp_c, rsp_v, rsp_result};
    endfunction

    // Driver: called at a negedge; issues one request, checks latency,
    // busy behaviour, the response, stability under stall, and handshake.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                          input int stall, output logic [12:0] obs);
        logic [12:0] exp;
        int lat, want_lat;
        exp_q.push_back(model(int'(a), int'(b), int'(op)));
        want_lat = (op == 4'd2 || op == 4'd3 || op == 4'd4) ? 5 : 2;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle op=%0d actual=%b required=1", op, req_ready);
        end
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        @(posedge clk); lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 4'($urandom_range(0, 15));
        req_b = 4'($urandom_range(0, 15));
        req_op = 4'($urandom_range(0, 15));
        while (rsp_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_busy op=%0d lat=%0d actual=%b required=0", op, lat, req_ready);
            end
            @(posedge clk); lat++;
            @(negedge clk);
        end
        obs = observed();
        exp = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout op=%0d actual=no_valid required=valid", op);
            return;
        end
        checks++;
        if (lat != want_lat) begin
            errors++;
            $display("FAIL latency op=%0d actual=%0d required=%0d", op, lat, want_lat);
        end
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL response op=%0d a=%0d b=%0d actual=%h required=%h", op, a, b, obs, exp);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || observed() !== exp || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold op=%0d cyc=%0d actual=%b/%h/%b required=1/%h/0",
                         op, i, rsp_valid, observed(), req_ready, exp);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake op=%0d actual=valid%b_ready%b required=valid0_ready1",
                     op, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = 4'd0; req_b = 4'd0; req_op = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs actual=ready%b_valid%b required=ready1_valid0", req_ready, rsp_valid);
        end
        checks++;
        if (observed() !== 13'h0) begin
            errors++;
            $display("FAIL reset_data actual=%h required=0000", observed());
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state actual=%0d required=%0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_add();
        logic [12:0] o;
        run_op(4'd7, 4'd8, 4'd0, 0, o);
        checks++;
        if (o[7:0] !== 8'd15 || o[11:9] !== 3'b100) begin
            errors++;
            $display("FAIL add_7_8 actual=%h required=res15_n1_z0_c0", o);
        end
    endtask

    task automatic test_sub();
        logic [12:0] o;
        run_op(4'd2, 4'd5, 4'd1, 0, o);
        checks++;
        if (o[7:0] !== 8'd13 || o[11:8] !== 4'b1010) begin
            errors++;
            $display("FAIL sub_2_5 actual=%h required=res13_nzcv1010", o);
        end
        run_op(4'd6, 4'd2, 4'd1, 0, o);
        checks++;
        if (o[7:0] !== 8'd4 || o[11:8] !== 4'b0000) begin
            errors++;
            $display("FAIL sub_6_2 actual=%h required=res4_nzcv0000", o);
        end
    endtask

    task automatic test_mul();
        logic [12:0] o;
        run_op(4'd4, 4'd4, 4'd2, 0, o);
        checks++;
        if (o[7:0] !== 8'h10 || o[11] !== 1'b0) begin
            errors++;
            $display("FAIL mul_4_4 actual=%h required=res10_n0", o);
        end
        run_op(4'd15, 4'd15, 4'd2, 1, o);
        checks++;
        if (o[7:0] !== 8'd225 || o[11] !== 1'b1) begin
            errors++;
            $display("FAIL mul_15_15 actual=%h required=resE1_n1", o);
        end
    endtask

    task automatic test_div();
        logic [12:0] o;
        run_op(4'd7, 4'd3, 4'd3, 0, o);
        checks++;
        if (o[7:0] !== 8'd2) begin errors++; $display("FAIL div_7_3 actual=%0d required=2", o[7:0]); end
        run_op(4'd8, 4'd3, 4'd4, 0, o);
        checks++;
        if (o[7:0] !== 8'd2) begin errors++; $display("FAIL mod_8_3 actual=%0d required=2", o[7:0]); end
        run_op(4'd5, 4'd0, 4'd3, 0, o);
        checks++;
        if (o[7:0] !== 8'd15 || o[12] !== ERR_EN || o[9:8] !== 2'b00) begin
            errors++;
            $display("FAIL div_by_zero actual=%h required=res15_err%0d_c0_v0", o, ERR_EN);
        end
        run_op(4'd5, 4'd0, 4'd4, 0, o);
        checks++;
        if (o[7:0] !== 8'd5 || o[12] !== ERR_EN) begin
            errors++;
            $display("FAIL mod_by_zero actual=%h required=res5_err%0d", o, ERR_EN);
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] o;
        run_op(4'b0011, 4'd1, 4'd8, 3, o);
        checks++;
        if (o[7:0] !== 8'd6) begin errors++; $display("FAIL shl_3_1 actual=%0d required=6", o[7:0]); end
        run_op(4'b1000, 4'd3, 4'd9, 0, o);
        checks++;
        if (o[7:0] !== 8'd1) begin errors++; $display("FAIL shr_8_3 actual=%0d required=1", o[7:0]); end
        run_op(4'd9, 4'd4, 4'd8, 2, o);
        checks++;
        if (o[7:0] !== 8'd0 || o[10] !== 1'b1) begin
            errors++;
            $display("FAIL shl_big actual=%h required=res0_z1", o);
        end
        run_op(4'd3, 4'd3, 4'd12, 0, o);
        checks++;
        if (o[11:0] !== 12'h400 || o[12] !== ERR_EN) begin
            errors++;
            $display("FAIL unsupported_op actual=%h required=z_only_err%0d", o, ERR_EN);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [12:0] o;
        req_valid = 1'b1; req_a = 4'd4; req_b = 4'd4; req_op = 4'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || observed() !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_mul actual=valid%b_ready%b_data%h required=valid0_ready1_data0000",
                     rsp_valid, req_ready, observed());
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL aborted_rsp cyc=%0d actual=%b required=0", i, rsp_valid);
            end
        end
        run_op(4'd3, 4'd2, 4'd0, 0, o);
        checks++;
        if (o[7:0] !== 8'd5) begin errors++; $display("FAIL add_after_reset actual=%0d required=5", o[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] o;
        run_op(4'd9, 4'd9, 4'd0, 0, o);
        run_op(4'd12, 4'd10, 4'd5, 0, o);
        run_op(4'd11, 4'd13, 4'd2, 0, o);
        run_op(4'd14, 4'd4, 4'd3, 0, o);
        run_op(4'd8, 4'd1, 4'd1, 0, o);
    endtask

    task automatic test_random();
        logic [12:0] o;
        for (int i = 0; i < 120; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
